// File: rtl/div_share_arbiter.sv
// div_share_arbiter
//   Shares one serial-load divider (operands on a single W-bit bus, with a
//   Start/Stop handshake) among NREQ requesters. A round-robin pick runs in
//   IDLE, and the winner's operands are latched. The divider is then loaded
//   with the dividend followed by the divisor. The arbiter waits for Stop and
//   returns the quotient with a one-cycle done pulse. A divisor of zero is
//   answered without touching the divider. A hung divider is aborted after
//   TIMEOUT cycles.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   req[NREQ]           per-requester request level
//   dividend/divisor    packed operands, requester i at [i*W +: W]
//   gnt[NREQ]           one-hot grant, held from grant through the done cycle
//   done[NREQ]          one-cycle completion pulse to the served requester
//   result[W], err      quotient / error flag, valid while any done bit is high
//   busy                high whenever the arbiter is not idle
//   div_data, div_start divider data bus and Start strobe
//   div_stop, div_quot  divider completion level and quotient
module div_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] dividend,
  input  logic [NREQ*W-1:0] divisor,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      result,
  output logic              err,
  output logic              busy,
  output logic [W-1:0]      div_data,
  output logic              div_start,
  input  logic              div_stop,
  input  logic [W-1:0]      div_quot
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              dz_q, dz_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [W-1:0]      result_q, result_d;
  logic              err_q, err_d;
  logic [W-1:0]      data_q, data_d;
  logic              start_q, start_d;

  // Round-robin pick: first requester at or after the pointer, wrapping.
  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  logic [W-1:0]      sel_a;
  logic [W-1:0]      sel_b;
  logic [IW-1:0]     ptr_next;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!sel_found && req[(32'(ptr_q) + k) % NREQ]) begin
        sel_found = 1'b1;
        sel_idx   = IW'((32'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign sel_a    = dividend[32'(sel_idx)*W +: W];
  assign sel_b    = divisor[32'(sel_idx)*W +: W];
  assign ptr_next = (idx_q == IW'(NREQ-1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    result_d = result_q;
    err_d    = err_q;
    data_d   = data_q;
    start_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          idx_d          = sel_idx;
          a_d            = sel_a;
          b_d            = sel_b;
          dz_d           = (sel_b == '0);
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          state_d        = S_LOAD_A;
          // A zero divisor still takes the LOAD_A slot so its done pulse
          // lands two cycles after the request, but the divider bus stays
          // quiet: no Start and no data.
          if (sel_b != '0) begin
            start_d = 1'b1;
            data_d  = sel_a;
          end
        end
      end

      S_LOAD_A: begin
        if (dz_q) begin
          state_d        = S_DONE;
          done_d[idx_q]  = 1'b1;
          result_d       = '1;
          err_d          = 1'b1;
        end else begin
          state_d = S_LOAD_B;
          data_d  = b_q;
        end
      end

      S_LOAD_B: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end

      S_WAIT: begin
        // Stop takes priority over an expiry that falls in the same cycle.
        if (div_stop) begin
          state_d       = S_DONE;
          done_d[idx_q] = 1'b1;
          result_d      = div_quot;
          err_d         = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          state_d       = S_DONE;
          done_d[idx_q] = 1'b1;
          result_d      = '1;
          err_d         = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        err_d   = 1'b0;
        data_d  = '0;
        ptr_d   = ptr_next;
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        err_d   = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      data_q   <= data_d;
      start_q  <= start_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);
  assign div_data  = data_q;
  assign div_start = start_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
module tb_div_share_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned W       = 16;
  localparam int unsigned TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] dividend = '0;
  logic [NREQ*W-1:0] divisor = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      result;
  logic              err;
  logic              busy;
  logic [W-1:0]      div_data;
  logic              div_start;
  logic              div_stop = 1'b0;
  logic [W-1:0]      div_quot = '0;

  div_share_arbiter #(
    .NREQ    (NREQ),
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .dividend  (dividend),
    .divisor   (divisor),
    .gnt       (gnt),
    .done      (done),
    .result    (result),
    .err       (err),
    .busy      (busy),
    .div_data  (div_data),
    .div_start (div_start),
    .div_stop  (div_stop),
    .div_quot  (div_quot)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int          idx;
    logic [15:0] res;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  // Divider model: grabs dividend with Start, divisor the cycle after, and
  // raises Stop m_lat cycles later (m_lat == 0 means it never finishes).
  int          m_lat   = 4;
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [15:0] m_a     = '0;
  logic [15:0] m_b     = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (div_start) begin
        m_a      = div_data;
        m_phase  = 1;
        div_stop = 1'b0;
      end else if (m_phase == 1) begin
        m_b     = div_data;
        m_cnt   = 0;
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_cnt++;
        if (m_lat != 0 && m_cnt == m_lat) begin
          div_quot = (m_b != 0) ? m_a / m_b : 16'h0;
          div_stop = 1'b1;
          m_phase  = 0;
        end
      end
    end
  end

  // Scoreboard: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && |done) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_done: done=%b result=%h err=%b", done, result, err);
      end else begin
        exp_t        e;
        logic [3:0]  eoh;
        e   = sbq.pop_front();
        eoh = 4'b0001 << e.idx;
        if ({done, gnt, result, err} !== {eoh, eoh, e.res, e.err}) begin
          n_miss++;
          $display("FAIL done_check: got done=%b gnt=%b result=%h err=%b, want done=%b gnt=%b result=%h err=%b",
                   done, gnt, result, err, eoh, eoh, e.res, e.err);
        end
      end
    end
  end

  task automatic push_exp(input int idx, input logic [15:0] res, input logic e);
    exp_t x;
    x.idx = idx;
    x.res = res;
    x.err = e;
    sbq.push_back(x);
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    dividend[i*W +: W] = a;
    divisor[i*W +: W]  = b;
  endtask

  // Waits for a done pulse; n is the number of falling edges waited, -1 on expiry.
  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (|done) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    div_stop = 1'b0;
    m_phase  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    #1;
    n_vec++;
    if ({gnt, done, result, err, busy, div_data, div_start} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs: got gnt=%b done=%b result=%h err=%b busy=%b data=%h start=%b, want all 0",
               gnt, done, result, err, busy, div_data, div_start);
    end
    do_reset();
    n_vec++;
    if ({gnt, done, busy, div_start} !== '0) begin
      n_miss++;
      $display("FAIL reset_release_idle: got gnt=%b done=%b busy=%b start=%b, want 0", gnt, done, busy, div_start);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    m_lat = 10;
    set_ops(0, 16'd52, 16'd7);
    push_exp(0, 16'd7, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    n_vec++;
    if ({gnt, div_start, div_data} !== {4'b0001, 1'b1, 16'd52}) begin
      n_miss++;
      $display("FAIL single_load_a: got gnt=%b start=%b data=%0d, want 0001 1 52", gnt, div_start, div_data);
    end
    req = '0;
    @(negedge clk);
    n_vec++;
    if ({div_start, div_data, busy} !== {1'b0, 16'd7, 1'b1}) begin
      n_miss++;
      $display("FAIL single_load_b: got start=%b data=%0d busy=%b, want 0 7 1", div_start, div_data, busy);
    end
    wait_done(60, n);
    n_vec++;
    if (n != 11) begin
      n_miss++;
      $display("FAIL single_latency: got %0d, want 11", n);
    end
    @(negedge clk);
    n_vec++;
    if ({busy, gnt, done, err, div_data} !== '0) begin
      n_miss++;
      $display("FAIL single_after: got busy=%b gnt=%b done=%b err=%b data=%h, want 0", busy, gnt, done, err, div_data);
    end
  endtask

  task automatic test_fairness();
    int n;
    logic [3:0] nxt;
    do_reset();
    m_lat = 3;
    for (int i = 0; i < 4; i++) set_ops(i, 16'(9 + 3*i), 16'd3);
    push_exp(0, 16'd3, 1'b0);
    push_exp(1, 16'd4, 1'b0);
    push_exp(2, 16'd5, 1'b0);
    push_exp(3, 16'd6, 1'b0);
    push_exp(0, 16'd3, 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_done(40, n);
      n_vec++;
      if (n < 0) begin
        n_miss++;
        $display("FAIL fair_timeout: op %0d got no done, want done", i);
      end
      if (i == 4) begin
        req = '0;
      end else begin
        nxt = 4'b0001 << ((i + 1) % 4);
        @(negedge clk);
        n_vec++;
        if ({busy, gnt} !== {1'b0, 4'b0000}) begin
          n_miss++;
          $display("FAIL fair_idle_gap: got busy=%b gnt=%b, want 0 0000", busy, gnt);
        end
        @(negedge clk);
        n_vec++;
        if (gnt !== nxt) begin
          n_miss++;
          $display("FAIL fair_order: got gnt=%b, want %b", gnt, nxt);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_div0();
    do_reset();
    set_ops(2, 16'd100, 16'd0);
    push_exp(2, 16'hFFFF, 1'b1);
    req = 4'b0100;
    @(negedge clk);
    n_vec++;
    if ({gnt, done, div_start, div_data} !== {4'b0100, 4'b0000, 1'b0, 16'd0}) begin
      n_miss++;
      $display("FAIL div0_first: got gnt=%b done=%b start=%b data=%h, want 0100 0000 0 0000", gnt, done, div_start, div_data);
    end
    req = '0;
    @(negedge clk);
    n_vec++;
    if ({done, div_start} !== {4'b0100, 1'b0}) begin
      n_miss++;
      $display("FAIL div0_done_timing: got done=%b start=%b, want 0100 0", done, div_start);
    end
    @(negedge clk);
    n_vec++;
    if ({busy, gnt, err} !== '0) begin
      n_miss++;
      $display("FAIL div0_after: got busy=%b gnt=%b err=%b, want 0", busy, gnt, err);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    m_lat = 0;
    set_ops(0, 16'd20, 16'd4);
    push_exp(0, 16'hFFFF, 1'b1);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    wait_done(TIMEOUT + 20, n);
    n_vec++;
    if (n != TIMEOUT + 2) begin
      n_miss++;
      $display("FAIL timeout_latency: got %0d, want %0d", n, TIMEOUT + 2);
    end
    @(negedge clk);
    m_lat = TIMEOUT;
    push_exp(0, 16'd5, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    wait_done(TIMEOUT + 20, n);
    n_vec++;
    if (n != TIMEOUT + 2) begin
      n_miss++;
      $display("FAIL stop_at_expiry_latency: got %0d, want %0d", n, TIMEOUT + 2);
    end
    @(negedge clk);
  endtask

  task automatic test_opchange();
    int n;
    do_reset();
    m_lat = 5;
    set_ops(1, 16'd40, 16'd8);
    push_exp(1, 16'd5, 1'b0);
    req = 4'b0010;
    @(negedge clk);
    n_vec++;
    if (gnt !== 4'b0010) begin
      n_miss++;
      $display("FAIL opchg_grant: got gnt=%b, want 0010", gnt);
    end
    set_ops(1, 16'd99, 16'd1);
    req = '0;
    wait_done(40, n);
    n_vec++;
    if (n < 0) begin
      n_miss++;
      $display("FAIL opchg_done: got no done, want done[1]");
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    m_lat = 4;
    set_ops(1, 16'd9, 16'd3);
    push_exp(1, 16'd3, 1'b0);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    wait_done(40, n);
    @(negedge clk);
    m_lat = 0;
    set_ops(3, 16'd30, 16'd6);
    req = 4'b1000;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({gnt, done, result, err, busy, div_data, div_start} !== '0) begin
      n_miss++;
      $display("FAIL reset_mid_outputs: got gnt=%b done=%b result=%h err=%b busy=%b data=%h start=%b, want all 0",
               gnt, done, result, err, busy, div_data, div_start);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    m_lat   = 4;
    m_phase = 0;
    div_stop = 1'b0;
    set_ops(0, 16'd14, 16'd7);
    push_exp(0, 16'd2, 1'b0);
    push_exp(3, 16'd5, 1'b0);
    req = 4'b1001;
    wait_done(40, n);
    req = 4'b1000;
    wait_done(40, n);
    req = '0;
    n_vec++;
    if (n < 0) begin
      n_miss++;
      $display("FAIL reset_mid_resume: got no done, want done[3]");
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sbq.size() != 0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending busy=%b, want 0 0", sbq.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_div0();
    test_timeout();
    test_opchange();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1);
  end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one serial-load divider datapath (operands on a single 16-bit bus, Start/Stop handshake) among NREQ requesters.
- Arbitrates round-robin and latches the granted requester's operands.
- Sequences the divider load (dividend, then divisor), waits for Stop, captures the quotient and returns it to the requester with a one-cycle done pulse.
- Short-circuits divide-by-zero and aborts hung operations via a timeout.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 16, operand/quotient width; matches the divider data bus
- TIMEOUT, 64, max cycles in WAIT before abort (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- dividend  in  NREQ*W  packed operands; requester i at [i*W +: W]
- divisor  in  NREQ*W  packed operands; requester i at [i*W +: W]
- gnt  out  NREQ  one-hot, high from grant until done cycle inclusive
- done  out  NREQ  one-cycle pulse to the served requester
- result  out  W  quotient; valid only while any done bit is high
- err  out  1  high with done when the result is an error (div-by-zero or timeout)
- busy  out  1  high in any state except IDLE
- div_data  out  W  divider Data_in bus
- div_start  out  1  divider Start
- div_stop  in  1  divider Stop (completion level)
- div_quot  in  W  divider quotient

Behaviour:
- Reset (async, rst_n=0): state IDLE, RR pointer=0, gnt=0, done=0, result=0, err=0, busy=0, div_data=0, div_start=0, timeout counter=0, operand latches=0.
- All outputs are registered or decoded from registered state only; no combinational path from req/operand inputs to outputs.
- States: IDLE, LOAD_A, LOAD_B, WAIT, DONE.
- IDLE:
  - If any req is high, select the first requester at or after the pointer (wrapping NREQ-1 -> 0).
  - Latch its index, dividend and divisor; set gnt one-hot.
  - Divisor==0: go to DONE with err=1, result={W{1}}; the datapath is untouched.
  - Otherwise go to LOAD_A.
  - No req: stay in IDLE.
- LOAD_A (1 cycle): div_start=1, div_data=latched dividend.
- LOAD_B (1 cycle): div_start=0, div_data=latched divisor.
- WAIT:
  - div_data holds the divisor; the counter increments each cycle from 0.
  - div_stop=1: capture div_quot into result, err=0, go to DONE.
  - Counter reaches TIMEOUT-1 without Stop: result={W{1}}, err=1, go to DONE.
  - Stop in the same cycle as expiry: Stop wins (normal result).
- DONE (1 cycle):
  - done[idx]=1; gnt still asserted; result and err valid.
  - Pointer becomes idx+1 mod NREQ.
  - Next state IDLE; gnt, done and err clear on the following cycle.
  - div_data returns to 0.
- Latency, req at edge k in IDLE: gnt from k+1, div_start at k+1, divisor on bus k+2, WAIT from k+3. Done comes 1 cycle after Stop is sampled. Divide-by-zero: done 2 cycles after the req edge.
- div_stop sampled outside WAIT is ignored.
- Operands are latched at grant. Later changes to dividend/divisor and drops of req are ignored; the op completes and done is still pulsed.
- A requester whose req stays high after done competes again. Back-to-back ops have 1 IDLE cycle between them.
- Requests arriving while busy wait. Round-robin guarantees service within NREQ operations.
- Reset asserted mid-operation aborts immediately; no done is issued.

Test Plan:
- Single op: req[0], dividend=52, divisor=7; model divider returns 7 after 10 cycles -> div_start one cycle with div_data=52, then div_data=7; done[0] with result=7, err=0.
- Fairness: req=4'b1111 held, all divisors 3, dividends 9/12/15/18 -> grant order 0,1,2,3,0; results 3/4/5/6.
- Divide-by-zero: req[2], dividend=100, divisor=0 -> div_start never asserts; done[2] 2 cycles after the req edge, result=16'hFFFF, err=1.
- Timeout: model never asserts Stop -> done after TIMEOUT cycles in WAIT, err=1, result=16'hFFFF. Stop forced at exactly the expiry cycle -> normal result, err=0.
- Operand change/req drop: change dividend to 99 and drop req[1] in the cycle after grant -> result uses the originally latched values; done[1] still pulses.
- Reset mid-WAIT: pull rst_n low asynchronously -> all outputs 0 immediately; after release the pointer is 0 and a pending req[3] is served normally.
